riscv_retire_tracer: RTL and testbench

- Sits at the WB stage of riscv_cpu and is the producing end of the retirement-checking path.
- Captures one record per retired instruction: instruction word, pc, next_pc, rs1/rs2 values, rd writeback value and memory word.
- Buffers records in a small FIFO and serialises each one as an 8-word stream packet with valid/ready handshaking, for a bench-side or off-chip checker.
- Reports dropped records and signals completion after halt once all buffered records have drained.

---
 rtl/riscv_retire_tracer.sv | 195 +++++++++++++++++++
 tb/tb_riscv_retire_tracer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_retire_tracer.sv
// riscv_retire_tracer: captures one record per retired instruction at WB,
// buffers records in a small FIFO and serialises each as an 8-word packet
// on a valid/ready stream. Tracks dropped records and reports completion
// once the CPU has halted and every buffered record has drained.
module riscv_retire_tracer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SEQ_W      = 16,
  parameter int unsigned DROP_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  input  logic [31:0]       wb_instr,
  input  logic [31:0]       wb_pc,
  input  logic [31:0]       wb_next_pc,
  input  logic [31:0]       wb_rs1_data,
  input  logic [31:0]       wb_rs2_data,
  input  logic [31:0]       wb_rd_data,
  input  logic [31:0]       wb_mem_data,
  input  logic              halt_in,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [31:0]       tr_data,
  output logic              tr_last,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic              done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // w[0]=instr, w[1]=pc, w[2]=next_pc, w[3]=rs1, w[4]=rs2, w[5]=rd, w[6]=mem
  typedef struct packed {
    logic [SEQ_W-1:0]  seq;
    logic              ovf;
    logic [6:0][31:0]  w;
  } rec_t;

  rec_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       idx_q, idx_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  state_e           state_q, state_d;

  logic  fifo_empty;
  logic  fifo_full;
  logic  capture_en;
  logic  stream_valid;
  logic  handshake;
  logic  pop;
  logic  push;
  logic  drop;
  rec_t  head;
  rec_t  new_rec;
  logic [15:0] seq16;

  // Header carries exactly 16 sequence bits: zero-extend or truncate.
  if (SEQ_W >= 16) begin : g_seq_trunc
    assign seq16 = head.seq[15:0];
  end else begin : g_seq_ext
    assign seq16 = {{(16 - SEQ_W){1'b0}}, head.seq};
  end

  // FIFO status, handshake and capture decisions.
  always_comb begin
    fifo_empty   = (count_q == '0);
    fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
    stream_valid = !fifo_empty && ((state_q == ST_SEND) || (state_q == ST_DRAIN));
    handshake    = stream_valid && tr_ready;
    pop          = handshake && (idx_q == 3'd7);
    capture_en   = (state_q == ST_IDLE) || (state_q == ST_SEND);
    // A full FIFO still accepts when its head retires its last word this edge.
    push         = wb_valid && capture_en && (!fifo_full || pop);
    drop         = wb_valid && capture_en && !push;
    head         = mem_q[rd_ptr_q];

    new_rec      = '0;
    new_rec.seq  = seq_q;
    new_rec.ovf  = ovf_q;
    new_rec.w[0] = wb_instr;
    new_rec.w[1] = wb_pc;
    new_rec.w[2] = wb_next_pc;
    new_rec.w[3] = wb_rs1_data;
    new_rec.w[4] = wb_rs2_data;
    new_rec.w[5] = wb_rd_data;
    new_rec.w[6] = wb_mem_data;
  end

  // Stream outputs: word selected from the head record by the word index.
  always_comb begin
    tr_valid   = stream_valid;
    tr_last    = stream_valid && (idx_q == 3'd7);
    tr_data    = '0;
    if (stream_valid) begin
      if (idx_q == 3'd0) begin
        tr_data = {8'hA5, head.ovf, 7'b0, seq16};
      end else begin
        tr_data = head.w[idx_q - 3'd1];
      end
    end
    overflow   = ovf_q;
    drop_count = drop_q;
    done       = (state_q == ST_DONE);
  end

  // Next-state for pointers, counters, sticky flags and the control FSM.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end
    idx_d  = handshake ? idx_q + 3'd1 : idx_q;
    seq_d  = (wb_valid && capture_en) ? seq_q + SEQ_W'(1) : seq_q;
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_q != '1) begin
        drop_d = drop_q + DROP_W'(1);
      end
    end

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (halt_in) begin
          state_d = ST_DRAIN;
        end else if (push) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (halt_in) begin
          state_d = ST_DRAIN;
        end else if (count_d == '0) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (count_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      seq_q    <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      seq_q    <= seq_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
    end
  end

  // Record storage; contents are only observed through count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_rec;
    end
  end

endmodule

// File: tb/tb_riscv_retire_tracer.sv
// Directed bench for riscv_retire_tracer: packet format, backpressure,
// overflow, full push/pop, halt drain and reset behaviour.
module tb_riscv_retire_tracer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_instr = '0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_next_pc = '0;
  logic [31:0] wb_rs1_data = '0;
  logic [31:0] wb_rs2_data = '0;
  logic [31:0] wb_rd_data = '0;
  logic [31:0] wb_mem_data = '0;
  logic        halt_in = 1'b0;
  logic        tr_valid;
  logic        tr_ready = 1'b0;
  logic [31:0] tr_data;
  logic        tr_last;
  logic        overflow;
  logic [15:0] drop_count;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rx_w [8];
  logic        rx_last_ok;
  logic        rx_to;

  riscv_retire_tracer #(
    .FIFO_DEPTH(4),
    .SEQ_W(16),
    .DROP_W(16)
  ) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_instr(wb_instr),
    .wb_pc(wb_pc), .wb_next_pc(wb_next_pc), .wb_rs1_data(wb_rs1_data),
    .wb_rs2_data(wb_rs2_data), .wb_rd_data(wb_rd_data),
    .wb_mem_data(wb_mem_data), .halt_in(halt_in), .tr_valid(tr_valid),
    .tr_ready(tr_ready), .tr_data(tr_data), .tr_last(tr_last),
    .overflow(overflow), .drop_count(drop_count), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; halt_in = 1'b0; wb_valid = 1'b0; tr_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic retire(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] npc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] rd,
                        input logic [31:0] mem);
    wb_instr = instr; wb_pc = pc; wb_next_pc = npc; wb_rs1_data = rs1;
    wb_rs2_data = rs2; wb_rd_data = rd; wb_mem_data = mem;
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
  endtask

  // Collect one packet with tr_ready held high, bounded wait per word.
  task automatic rx_packet();
    int guard;
    rx_to = 1'b0; rx_last_ok = 1'b1; tr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      guard = 0;
      while (!tr_valid && guard < 50) begin step(); guard++; end
      if (!tr_valid) begin rx_to = 1'b1; break; end
      rx_w[k] = tr_data;
      if (tr_last !== (k == 7)) rx_last_ok = 1'b0;
      step();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tr_valid got=%b exp=0", tr_valid); end
    n_checks++; if (tr_data !== 32'h0) begin n_fail++; $display("FAIL reset_tr_data got=%h exp=0", tr_data); end
    n_checks++; if (tr_last !== 1'b0) begin n_fail++; $display("FAIL reset_tr_last got=%b exp=0", tr_last); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    n_checks++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL reset_drop_count got=%0d exp=0", drop_count); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_single();
    logic [31:0] exp [8];
    exp = '{32'hA5000000, 32'h00500093, 32'h0, 32'h4, 32'h0, 32'h0, 32'h5, 32'h0};
    do_reset();
    tr_ready = 1'b1;
    retire(32'h00500093, 32'h0, 32'h4, 32'h0, 32'h0, 32'h5, 32'h0);
    for (int k = 0; k < 8; k++) begin
      n_checks++; if (tr_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid w%0d got=%b exp=1", k, tr_valid); end
      n_checks++; if (tr_data !== exp[k]) begin n_fail++; $display("FAIL single_data w%0d got=%h exp=%h", k, tr_data, exp[k]); end
      n_checks++; if (tr_last !== (k == 7)) begin n_fail++; $display("FAIL single_last w%0d got=%b exp=%b", k, tr_last, (k == 7)); end
      step();
    end
    n_checks++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL single_after got=%b exp=0", tr_valid); end
    step();
    n_checks++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL single_after2 got=%b exp=0", tr_valid); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [8];
    exp = '{32'hA5000000, 32'h11111111, 32'h100, 32'h104,
            32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004};
    do_reset();
    tr_ready = 1'b1;
    retire(32'h11111111, 32'h100, 32'h104, 32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004);
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin
        tr_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          step();
          n_checks++; if (tr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid c%0d got=%b exp=1", s, tr_valid); end
          n_checks++; if (tr_data !== exp[3]) begin n_fail++; $display("FAIL bp_hold_data c%0d got=%h exp=%h", s, tr_data, exp[3]); end
        end
        tr_ready = 1'b1;
      end
      n_checks++; if (tr_data !== exp[k]) begin n_fail++; $display("FAIL bp_data w%0d got=%h exp=%h", k, tr_data, exp[k]); end
      n_checks++; if (tr_last !== (k == 7)) begin n_fail++; $display("FAIL bp_last w%0d got=%b exp=%b", k, tr_last, (k == 7)); end
      step();
    end
    n_checks++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL bp_after got=%b exp=0", tr_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 6; i++) retire(32'h1000 + 32'(i), 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_count got=%0d exp=2", drop_count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    for (int i = 0; i < 4; i++) begin
      rx_packet();
      n_checks++; if (rx_to !== 1'b0) begin n_fail++; $display("FAIL ovf_rx_timeout r%0d got=%b exp=0", i, rx_to); end
      n_checks++; if (rx_w[0] !== (32'hA5000000 | 32'(i))) begin n_fail++; $display("FAIL ovf_header r%0d got=%h exp=%h", i, rx_w[0], 32'hA5000000 | 32'(i)); end
      n_checks++; if (rx_w[1] !== 32'h1000 + 32'(i)) begin n_fail++; $display("FAIL ovf_instr r%0d got=%h exp=%h", i, rx_w[1], 32'h1000 + 32'(i)); end
      n_checks++; if (rx_last_ok !== 1'b1) begin n_fail++; $display("FAIL ovf_last r%0d got=%b exp=1", i, rx_last_ok); end
    end
    n_checks++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty got=%b exp=0", tr_valid); end
    retire(32'h1006, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    rx_packet();
    n_checks++; if (rx_w[0] !== 32'hA5800006) begin n_fail++; $display("FAIL ovf_header7 got=%h exp=a5800006", rx_w[0]); end
    n_checks++; if (drop_count !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_after got=%0d exp=2", drop_count); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_instr [4];
    exp_instr = '{32'h2001, 32'h2002, 32'h2003, 32'h77};
    do_reset();
    for (int i = 0; i < 4; i++) retire(32'h2000 + 32'(i), 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3000 + 32'(i));
    tr_ready = 1'b1;
    for (int s = 0; s < 7; s++) step();
    n_checks++; if (tr_last !== 1'b1) begin n_fail++; $display("FAIL fpp_at_w7 got=%b exp=1", tr_last); end
    n_checks++; if (tr_data !== 32'h3000) begin n_fail++; $display("FAIL fpp_w7_data got=%h exp=00003000", tr_data); end
    retire(32'h77, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tr_ready = 1'b0;
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL fpp_no_drop got=%0d exp=0", drop_count); end
    n_checks++; if (tr_data !== 32'hA5000001) begin n_fail++; $display("FAIL fpp_next_head got=%h exp=a5000001", tr_data); end
    retire(32'h88, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks++; if (drop_count !== 16'd1) begin n_fail++; $display("FAIL fpp_still_full got=%0d exp=1", drop_count); end
    for (int i = 0; i < 4; i++) begin
      rx_packet();
      n_checks++; if (rx_w[0] !== (32'hA5000001 + 32'(i))) begin n_fail++; $display("FAIL fpp_header r%0d got=%h exp=%h", i, rx_w[0], 32'hA5000001 + 32'(i)); end
      n_checks++; if (rx_w[1] !== exp_instr[i]) begin n_fail++; $display("FAIL fpp_instr r%0d got=%h exp=%h", i, rx_w[1], exp_instr[i]); end
    end
  endtask

  task automatic test_halt_drain();
    logic [31:0] words [24];
    int got;
    int cyc;
    do_reset();
    for (int i = 0; i < 3; i++) retire(32'h4000 + 32'(i), 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5000 + 32'(i));
    halt_in = 1'b1;
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL drain_done_early got=%b exp=0", done); end
    got = 0; cyc = 0;
    while (got < 24 && cyc < 200) begin
      tr_ready = (cyc % 2 == 1);
      wb_valid = (cyc % 3 == 0);
      wb_instr = 32'hDEAD0000 + 32'(cyc);
      if (tr_valid && tr_ready) begin words[got] = tr_data; got++; end
      step();
      cyc++;
    end
    wb_valid = 1'b0;
    n_checks++; if (got !== 24) begin n_fail++; $display("FAIL drain_word_count got=%0d exp=24", got); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL drain_done got=%b exp=1", done); end
    n_checks++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid_off got=%b exp=0", tr_valid); end
    for (int r = 0; r < 3; r++) begin
      n_checks++; if (words[8*r] !== 32'hA5000000 + 32'(r)) begin n_fail++; $display("FAIL drain_header r%0d got=%h exp=%h", r, words[8*r], 32'hA5000000 + 32'(r)); end
      n_checks++; if (words[8*r+1] !== 32'h4000 + 32'(r)) begin n_fail++; $display("FAIL drain_instr r%0d got=%h exp=%h", r, words[8*r+1], 32'h4000 + 32'(r)); end
      n_checks++; if (words[8*r+7] !== 32'h5000 + 32'(r)) begin n_fail++; $display("FAIL drain_mem r%0d got=%h exp=%h", r, words[8*r+7], 32'h5000 + 32'(r)); end
    end
    tr_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wb_valid = 1'b1;
      step();
      n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL drain_done_hold c%0d got=%b exp=1", s, done); end
      n_checks++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL drain_ignored c%0d got=%b exp=0", s, tr_valid); end
    end
    wb_valid = 1'b0;
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL drain_no_drop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_halt_boundaries();
    do_reset();
    halt_in = 1'b1;
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL halt_empty_d0 got=%b exp=0", done); end
    step();
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL halt_empty_d1 got=%b exp=1", done); end
    do_reset();
    halt_in = 1'b1;
    retire(32'hABCD0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks++; if (tr_data !== 32'hA5000000) begin n_fail++; $display("FAIL halt_same_cycle got=%h exp=a5000000", tr_data); end
    rx_packet();
    n_checks++; if (rx_w[1] !== 32'hABCD0001) begin n_fail++; $display("FAIL halt_same_instr got=%h exp=abcd0001", rx_w[1]); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL halt_same_done got=%b exp=1", done); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int i = 0; i < 5; i++) retire(32'h6000 + 32'(i), 32'h0, 32'h0, 32'h7000 + 32'(i), 32'h0, 32'h0, 32'h0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL rmp_pre_ovf got=%b exp=1", overflow); end
    tr_ready = 1'b1;
    for (int s = 0; s < 4; s++) step();
    n_checks++; if (tr_data !== 32'h7000) begin n_fail++; $display("FAIL rmp_at_w4 got=%h exp=00007000", tr_data); end
    rst = 1'b1;
    step();
    n_checks++; if (tr_valid !== 1'b0) begin n_fail++; $display("FAIL rmp_valid got=%b exp=0", tr_valid); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rmp_drop got=%0d exp=0", drop_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rmp_ovf got=%b exp=0", overflow); end
    rst = 1'b0;
    retire(32'h9999, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_checks++; if (tr_data !== 32'hA5000000) begin n_fail++; $display("FAIL rmp_new_header got=%h exp=a5000000", tr_data); end
    step();
    n_checks++; if (tr_data !== 32'h9999) begin n_fail++; $display("FAIL rmp_new_instr got=%h exp=00009999", tr_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_halt_drain();
    test_halt_boundaries();
    test_reset_mid_packet();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
